div_unit: RTL and testbench

- Multicycle restoring divider that produces the quotient/remainder pair for the CPU's divide instructions.
- Sits between the A/B operand registers and the MultOrDiv HI/LO selection muxes; HI receives the remainder and LO receives the quotient.
- Launched by a one-cycle start pulse from the control unit. Returns a one-cycle done pulse plus a divide-by-zero flag, which the control unit uses for its exception path.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/div_step.sv | 30 +++
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath word width and divider FSM states.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Shifted remainder keeps its carry-out bit so divisors with the MSB set
  // still compare correctly; the difference always fits back into WIDTH bits.
  always_comb begin
    shifted = {rem, q[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - divisor;
    if (shifted >= {1'b0, divisor}) begin
      rem_next = diff;
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multicycle restoring divider for div/divu: HI gets the remainder, LO the
// quotient. Signed operands are divided as magnitudes and fixed up at the end.
module div_unit
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  div_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] rem, rem_d;
  logic [WIDTH-1:0] quo, quo_d;
  logic [WIDTH-1:0] dvs, dvs_d;
  logic             sign_q, sign_q_d;
  logic             sign_r, sign_r_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             busy_d, done_d, div_zero_d;
  logic [WIDTH-1:0] step_rem, step_q;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem),
    .q        (quo),
    .divisor  (dvs),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= DIV_IDLE;
    else        state <= state_d;
  end

  // Next-state and next-value logic for the datapath and outputs.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rem_d      = rem;
    quo_d      = quo;
    dvs_d      = dvs;
    sign_q_d   = sign_q;
    sign_r_d   = sign_r;
    hi_d       = hi_out;
    lo_d       = lo_out;
    busy_d     = busy;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    unique case (state)
      DIV_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            sign_q_d = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r_d = div_signed & dividend[WIDTH-1];
            quo_d    = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs_d    = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
            rem_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            busy_d   = 1'b1;
            state_d  = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = step_q;
        cnt_d = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        lo_d    = sign_q ? -quo : quo;
        hi_d    = sign_r ? -rem : rem;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      rem      <= rem_d;
      quo      <= quo_d;
      dvs      <= dvs_d;
      sign_q   <= sign_q_d;
      sign_r   <= sign_r_d;
      hi_out   <= hi_d;
      lo_out   <= lo_d;
      busy     <= busy_d;
      done     <= done_d;
      div_zero <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes reference results, a
// negedge monitor pops and compares whenever done pulses.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural reference: plain 64-bit integer division semantics.
  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi);
    longint na, nb, q, r;
    if (sgn) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'b0, a});
      nb = longint'({32'b0, b});
    end
    q  = na / nb;
    r  = na % nb;
    lo = q[31:0];
    hi = r[31:0];
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (div_zero && !done) check("div_zero_without_done", {31'b0, done}, 32'd1);
      if (done) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("lo_out", lo_out, e.lo);
          check("hi_out", hi_out, e.hi);
          check("div_zero", {31'b0, div_zero}, {31'b0, e.zero});
          check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    start      = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    if (b == 32'd0) begin
      e.lo   = last_lo;
      e.hi   = last_hi;
      e.zero = 1'b1;
      e.lat  = 0;
    end else begin
      ref_div(sgn, a, b, e.lo, e.hi);
      e.zero  = 1'b0;
      e.lat   = 33;
      last_lo = e.lo;
      last_hi = e.hi;
    end
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    div_signed = 1'($urandom);
    dividend   = $urandom;
    divisor    = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got %0d pending ops expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_hi"}, hi_out, 32'd0);
    check({tag, "_lo"}, lo_out, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_div_zero"}, {31'b0, div_zero}, 32'd0);
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    issue(1'b1, 32'd7, 32'd2);                 drain();
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);         drain();
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);         drain();
    issue(1'b0, 32'hFFFF_FFFF, 32'h10);        drain();

    // Divide by zero after a 3/1 result.
    issue(1'b1, 32'd7, 32'd2);                 drain();
    issue(1'b1, 32'd5, 32'd0);
    check("busy_on_zero", {31'b0, busy}, 32'd0);
    drain();
    repeat (2) begin
      @(negedge clk);
      check("busy_after_zero", {31'b0, busy}, 32'd0);
    end

    // Overflow with an ignored start pulse mid-run.
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    check("busy_mid_run", {31'b0, busy}, 32'd1);
    start = 1'b1; div_signed = 1'b0; dividend = 32'd1; divisor = 32'd1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Reset in the middle of a 100/7 division.
    issue(1'b0, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("reset_mid_op");
    sb.delete();
    last_lo = '0;
    last_hi = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue(1'b0, 32'd100, 32'd7);               drain();

    // Randomized operations, including zero and small divisors.
    for (int n = 0; n < 250; n++) begin
      int unsigned sel;
      logic [31:0] a, b;
      sel = $urandom_range(0, 9);
      a   = $urandom;
      if (sel == 0)      b = 32'd0;
      else if (sel < 4)  b = 32'($urandom_range(1, 20)) ^ ({32{sel[0]}});
      else               b = $urandom;
      if (b == 32'd0 && sel != 0) b = 32'd1;
      issue(1'($urandom), a, b);
      drain();
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
